// File: rtl/rca_wide_seq_adder.sv
`default_nettype none
// ============================================================================
//  Module   : rca_64bit / rca_wide_seq_adder
//  Brief    : 64-bit ripple-carry adder, and a sequencer that streams one
//             WORDS*64-bit addition through it a limb at a time, LSW first.
//  Revision : 1.0  initial release
// ============================================================================

module rca_64bit (
    input  logic [63:0] a,
    input  logic [63:0] b,
    input  logic        cin,
    output logic [63:0] sum,
    output logic        cout
);

    logic [64:0] w_c;

    assign w_c[0] = cin;

    for (genvar i = 0; i < 64; i++) begin : g_bit
        assign sum[i]   = a[i] ^ b[i] ^ w_c[i];
        assign w_c[i+1] = (a[i] & b[i]) | (w_c[i] & (a[i] ^ b[i]));
    end

    assign cout = w_c[64];

endmodule

module rca_wide_seq_adder #(
    parameter int WORDS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [64*WORDS-1:0]   in_a,
    input  logic [64*WORDS-1:0]   in_b,
    input  logic                  in_cin,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [64*WORDS-1:0]   out_sum,
    output logic                  out_cout
);

    localparam int                 c_idx_w = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [c_idx_w-1:0] c_last  = c_idx_w'(WORDS - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADD  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                  r_state;
    state_t                  w_state_next;
    logic [WORDS-1:0][63:0]  r_a;
    logic [WORDS-1:0][63:0]  r_b;
    logic [WORDS-1:0][63:0]  r_sum;
    logic [c_idx_w-1:0]      r_idx;
    logic                    r_carry;
    logic                    r_cout;
    logic [63:0]             w_limb_sum;
    logic                    w_limb_cout;

    // Single adder instance; the carry chain between limbs goes through r_carry.
    rca_64bit u_rca (
        .a    (r_a[r_idx]),
        .b    (r_b[r_idx]),
        .cin  (r_carry),
        .sum  (w_limb_sum),
        .cout (w_limb_cout)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: if (in_valid)          w_state_next = S_ADD;
            S_ADD:  if (r_idx == c_last)   w_state_next = S_DONE;
            S_DONE: if (out_ready)         w_state_next = S_IDLE;
            default:                       w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_idx   <= '0;
            r_carry <= 1'b0;
            r_cout  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_a     <= in_a;
                        r_b     <= in_b;
                        r_carry <= in_cin;
                        r_idx   <= '0;
                    end
                end
                S_ADD: begin
                    r_sum[r_idx] <= w_limb_sum;
                    r_carry      <= w_limb_cout;
                    // Index parks on the top limb rather than wrapping.
                    if (r_idx == c_last) begin
                        r_cout <= w_limb_cout;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = (r_state == S_DONE);
    assign out_sum   = r_sum;
    assign out_cout  = r_cout;

endmodule

`default_nettype wire

// File: tb/tb_rca_wide_seq_adder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_rca_wide_seq_adder
//  Brief    : Self-checking bench for rca_wide_seq_adder (WORDS=4).
//  Revision : 1.0  initial release
// ============================================================================

module tb_rca_wide_seq_adder;

    localparam int WORDS = 4;
    localparam int W     = 64 * WORDS;
    localparam int NRND  = 1000;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  in_a = '0;
    logic [W-1:0]  in_b = '0;
    logic          in_cin = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [W-1:0]  out_sum;
    logic          out_cout;

    int checks   = 0;
    int failures = 0;

    rca_wide_seq_adder #(.WORDS(WORDS)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_cin    (in_cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cout  (out_cout)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One full transaction: request, latency, result, optional back-pressure, release.
    task automatic do_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic cin, input int hold,
                         input logic [W-1:0] es, input logic ec);
        int n;
        @(negedge clk);
        in_a = a; in_b = b; in_cin = cin; in_valid = 1'b1; out_ready = 1'b0;
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_accept_wait"}, W'(in_ready), W'(1));
        @(posedge clk); #1;
        in_valid = 1'b0;
        // n counts edges including the accepting one.
        n = 1;
        while (!out_valid && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check({tag, "_latency"}, W'(n), W'(WORDS + 1));
        check({tag, "_sum"}, out_sum, es);
        check({tag, "_cout"}, W'(out_cout), W'(ec));
        check({tag, "_in_ready_done"}, W'(in_ready), W'(0));
        for (int k = 0; k < hold; k++) begin
            @(posedge clk); #1;
            check({tag, "_hold_valid"}, W'(out_valid), W'(1));
            check({tag, "_hold_sum"}, out_sum, es);
            check({tag, "_hold_in_ready"}, W'(in_ready), W'(0));
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({tag, "_release_valid"}, W'(out_valid), W'(0));
        check({tag, "_release_in_ready"}, W'(in_ready), W'(1));
    endtask

    function automatic logic [W-1:0] rnd_word();
        logic [W-1:0] v;
        for (int k = 0; k < W / 32; k++) v[k*32 +: 32] = $urandom();
        return v;
    endfunction

    initial begin
        logic [W-1:0] all1;
        logic [W-1:0] limb0_ones;
        logic [W-1:0] low3_ones;
        logic         seen;
        logic [W:0]   q[$];
        logic [W:0]   exp_full;
        logic [W-1:0] ra, rb;
        logic         rc, have;
        int           sent, rcvd, cycles;

        all1       = '1;
        limb0_ones = '0;
        limb0_ones[63:0] = '1;
        low3_ones  = '0;
        low3_ones[191:0] = '1;

        repeat (2) @(posedge clk);
        #1;
        check("reset_in_ready", W'(in_ready), W'(1));
        check("reset_out_valid", W'(out_valid), W'(0));
        check("reset_sum", out_sum, W'(0));
        check("reset_cout", W'(out_cout), W'(0));
        @(negedge clk);
        rst = 1'b0;

        do_op("small", W'(10), W'(35), 1'b0, 0, W'(45), 1'b0);
        do_op("limb_carry", limb0_ones, W'(1), 1'b0, 0, W'(1) << 64, 1'b0);
        do_op("full_wrap", all1, W'(0), 1'b1, 0, W'(0), 1'b1);
        do_op("three_limb", low3_ones, W'(1), 1'b0, 0, W'(1) << 192, 1'b0);
        do_op("backpress", W'(23), W'(132), 1'b1, 7, W'(156), 1'b0);

        // Reset during the second ADD cycle.
        @(negedge clk);
        in_a = W'(3846); in_b = W'(9654); in_cin = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        check("midrst_in_ready", W'(in_ready), W'(1));
        check("midrst_out_valid", W'(out_valid), W'(0));
        check("midrst_sum", out_sum, W'(0));
        check("midrst_cout", W'(out_cout), W'(0));
        @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < WORDS + 3; k++) begin
            @(posedge clk); #1;
            if (out_valid) seen = 1'b1;
        end
        check("midrst_no_valid", W'(seen), W'(0));
        do_op("after_rst", W'(866945), W'(3324752), 1'b1, 0, W'(4191698), 1'b0);

        // Random traffic with random handshakes against a W-bit model.
        sent = 0; rcvd = 0; cycles = 0; have = 1'b0;
        ra = '0; rb = '0; rc = 1'b0;
        while ((sent < NRND || rcvd < sent) && cycles < 60000) begin
            @(negedge clk);
            if (!have && sent < NRND && $urandom_range(3) != 0) begin
                ra = rnd_word();
                rb = rnd_word();
                rc = 1'($urandom_range(1));
                have = 1'b1;
            end
            in_valid  = have;
            in_a      = ra;
            in_b      = rb;
            in_cin    = rc;
            out_ready = 1'($urandom_range(1));
            if (in_valid && in_ready) begin
                q.push_back({1'b0, ra} + {1'b0, rb} + {{W{1'b0}}, rc});
                have = 1'b0;
                sent++;
            end
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    check("rnd_spurious", W'(1), W'(0));
                end else begin
                    exp_full = q.pop_front();
                    check("rnd_sum", out_sum, exp_full[W-1:0]);
                    check("rnd_cout", W'(out_cout), W'(exp_full[W]));
                end
                rcvd++;
            end
            cycles++;
        end
        @(negedge clk);
        in_valid = 1'b0;
        out_ready = 1'b0;
        check("rnd_sent", W'(sent), W'(NRND));
        check("rnd_received", W'(rcvd), W'(NRND));
        check("rnd_queue_empty", W'(q.size()), W'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
